// File: rtl/req_ack_done_responder.sv
// Target-side responder for the req/ack/done_xfr handshake: delayed single-cycle
// ack, a hold-stallable counted transfer, a done pulse, and initiator-abort detection.
module req_ack_done_responder #(
  parameter int unsigned ACK_DLY = 2,
  parameter int unsigned XFR_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       hold,
  output logic       ack,
  output logic       xfr_active,
  output logic [7:0] xfr_cnt,
  output logic       done_xfr,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Handshake: the initiator raises req and keeps it high until it has seen
  // done_xfr; ack and done_xfr are one-cycle pulses from this side; dropping req
  // before done_xfr is an abort (err), and req must fall for at least one edge
  // before the next request is accepted.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ACK  = 3'd2,
    S_XFR  = 3'd3,
    S_DONE = 3'd4,
    S_REL  = 3'd5
  } state_t;

  localparam logic [3:0] ACK_DLY_C = 4'(ACK_DLY);
  localparam logic [7:0] XFR_LEN_C = 8'(XFR_LEN);

  state_t     state_q, state_d;
  logic [3:0] dly_q, dly_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       in_xfr_q, in_xfr_d;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          dly_d   = ACK_DLY_C;
        end
      end
      S_WAIT: begin
        // A dropped request wins over delay expiry.
        if (!req) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (dly_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_XFR;
        cnt_d   = 8'd0;
      end
      S_XFR: begin
        if (!req) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (!hold) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == XFR_LEN_C) state_d = S_DONE;
        end
      end
      S_DONE: state_d = req ? S_REL : S_IDLE;
      S_REL:  if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d    = (state_d == S_ACK);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    in_xfr_d = (state_d == S_XFR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dly_q    <= 4'd0;
      cnt_q    <= 8'd0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      in_xfr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      in_xfr_q <= in_xfr_d;
    end
  end

  // A transfer cycle only counts when the stall is released for the coming edge.
  assign xfr_active = in_xfr_q & ~hold;
  assign ack        = ack_q;
  assign done_xfr   = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign xfr_cnt    = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_req_ack_done_responder.sv
// Bench for req_ack_done_responder: directed handshake scenarios plus randomized
// transfers checked against a trace model built from the handshake timing rules.
module tb_req_ack_done_responder;

  localparam int unsigned ACK_DLY = 2;
  localparam int unsigned XFR_LEN = 4;

  logic       clk = 1'b0;
  logic       rst, req, hold;
  logic       ack, xfr_active, done_xfr, busy, err;
  logic [7:0] xfr_cnt;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [12:0] exp_q[$];
  logic        req_q[$];
  logic        hold_q[$];
  logic [7:0]  last_cnt;

  always #5 clk = ~clk;

  req_ack_done_responder #(.ACK_DLY(ACK_DLY), .XFR_LEN(XFR_LEN)) dut (
    .clk(clk), .rst(rst), .req(req), .hold(hold),
    .ack(ack), .xfr_active(xfr_active), .xfr_cnt(xfr_cnt),
    .done_xfr(done_xfr), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  function automatic logic [12:0] outs();
    return {ack, xfr_active, done_xfr, err, busy, xfr_cnt};
  endfunction

  function automatic logic [12:0] ev(logic a, logic x, logic d, logic e, logic b, logic [7:0] c);
    return {a, x, d, e, b, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference trace of one well-behaved transfer: per sample, the inputs to drive
  // for the coming edge and the outputs required while they are applied.
  task automatic build_xfr(input int pre_gap, input int extra_rel, input int hold_pct);
    int   cnt;
    int   holds;
    logic h;
    cnt   = 0;
    holds = 0;
    for (int g = 0; g < pre_gap; g++) begin
      req_q.push_back(1'b0); hold_q.push_back(1'($urandom_range(1))); exp_q.push_back(ev(0, 0, 0, 0, 0, last_cnt));
    end
    req_q.push_back(1'b1); hold_q.push_back(1'($urandom_range(1))); exp_q.push_back(ev(0, 0, 0, 0, 0, last_cnt));
    for (int i = 0; i <= int'(ACK_DLY); i++) begin
      req_q.push_back(1'b1); hold_q.push_back(1'($urandom_range(1))); exp_q.push_back(ev(0, 0, 0, 0, 1, last_cnt));
    end
    req_q.push_back(1'b1); hold_q.push_back(1'($urandom_range(1))); exp_q.push_back(ev(1, 0, 0, 0, 1, last_cnt));
    while (cnt < int'(XFR_LEN)) begin
      h = (holds < 16) && ($urandom_range(99) < hold_pct);
      req_q.push_back(1'b1); hold_q.push_back(h); exp_q.push_back(ev(0, !h, 0, 0, 1, 8'(cnt)));
      if (h) holds++;
      else cnt++;
    end
    req_q.push_back(extra_rel > 0); hold_q.push_back(1'($urandom_range(1)));
    exp_q.push_back(ev(0, 0, 1, 0, 1, 8'(XFR_LEN)));
    for (int r = 0; r < extra_rel; r++) begin
      req_q.push_back(r != extra_rel - 1); hold_q.push_back(1'($urandom_range(1)));
      exp_q.push_back(ev(0, 0, 0, 0, 1, 8'(XFR_LEN)));
    end
    last_cnt = 8'(XFR_LEN);
  endtask

  task automatic play(input string name);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      logic [12:0] e;
      e    = exp_q.pop_front();
      req  = req_q.pop_front();
      hold = hold_q.pop_front();
      #1;
      n_cmp++;
      if (outs() !== e) begin
        n_err++;
        $display("FAIL %s_s%0d: got %h want %h (ack,act,done,err,busy,cnt)", name, i, outs(), e);
      end
      @(posedge clk);
      #1;
      i++;
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; hold = 1'b1;
    step();
    step();
    n_cmp++;
    if (outs() !== 13'd0) begin
      n_err++; $display("FAIL reset_hold: got %h want %h", outs(), 13'd0);
    end
    rst = 1'b0; req = 1'b0; hold = 1'b0;
    step();
    n_cmp++;
    if (outs() !== 13'd0) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", outs(), 13'd0);
    end
    last_cnt = 8'd0;
  endtask

  task automatic test_basic();
    logic [12:0] e;
    req = 1'b1; hold = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) req = 1'b0;
      step();
      e = ev(k == 3, k >= 4 && k <= 7, k == 8, 0, k < 10,
             (k <= 4) ? 8'd0 : (k <= 8) ? 8'(k - 4) : 8'd4);
      n_cmp++;
      if (outs() !== e) begin
        n_err++; $display("FAIL basic_e%0d: got %h want %h", k, outs(), e);
      end
    end
    last_cnt = 8'd4;
  endtask

  task automatic test_stall();
    logic [12:0] e;
    logic [7:0]  c;
    req = 1'b1; hold = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      step();
      hold = (k >= 5 && k <= 7);
      #1;
      c = (k <= 3) ? last_cnt : (k == 4) ? 8'd0 : (k <= 8) ? 8'd1 : 8'(k - 7);
      e = ev(k == 3, k >= 4 && k <= 10 && !(k >= 5 && k <= 7), k == 11, 0, 1, c);
      n_cmp++;
      if (outs() !== e) begin
        n_err++; $display("FAIL stall_e%0d: got %h want %h", k, outs(), e);
      end
    end
    hold = 1'b0; req = 1'b0;
    step();
    n_cmp++;
    if (outs() !== ev(0, 0, 0, 0, 0, 8'd4)) begin
      n_err++; $display("FAIL stall_release: got %h want %h", outs(), ev(0, 0, 0, 0, 0, 8'd4));
    end
    last_cnt = 8'd4;
  endtask

  task automatic test_wait_drop();
    // Drop after one WAIT edge, then drop exactly on the edge the delay expires.
    for (int r = 0; r < 2; r++) begin
      int drop_at;
      drop_at = (r == 0) ? 1 : int'(ACK_DLY) + 1;
      req = 1'b1;
      for (int k = 0; k < drop_at; k++) begin
        step();
        n_cmp++;
        if (outs() !== ev(0, 0, 0, 0, 1, last_cnt)) begin
          n_err++; $display("FAIL wait_r%0d_e%0d: got %h want %h", r, k, outs(), ev(0, 0, 0, 0, 1, last_cnt));
        end
      end
      req = 1'b0;
      step();
      n_cmp++;
      if (outs() !== ev(0, 0, 0, 1, 0, last_cnt)) begin
        n_err++; $display("FAIL wait_err_r%0d: got %h want %h", r, outs(), ev(0, 0, 0, 1, 0, last_cnt));
      end
      step();
      n_cmp++;
      if (outs() !== ev(0, 0, 0, 0, 0, last_cnt)) begin
        n_err++; $display("FAIL wait_quiet_r%0d: got %h want %h", r, outs(), ev(0, 0, 0, 0, 0, last_cnt));
      end
    end
  endtask

  task automatic test_xfr_abort();
    logic [12:0] e;
    // Abort after two counted cycles, then on the final counting edge.
    for (int r = 0; r < 2; r++) begin
      req = 1'b1; hold = 1'b0;
      for (int k = 0; k <= 6 + r; k++) begin
        step();
        e = ev(k == 3, k >= 4, 0, 0, 1, (k >= 4) ? 8'(k - 4) : last_cnt);
        n_cmp++;
        if (outs() !== e) begin
          n_err++; $display("FAIL abort_r%0d_e%0d: got %h want %h", r, k, outs(), e);
        end
      end
      req = 1'b0;
      step();
      n_cmp++;
      if (outs() !== ev(0, 0, 0, 1, 0, 8'd0)) begin
        n_err++; $display("FAIL abort_err_r%0d: got %h want %h", r, outs(), ev(0, 0, 0, 1, 0, 8'd0));
      end
      step();
      n_cmp++;
      if (outs() !== ev(0, 0, 0, 0, 0, 8'd0)) begin
        n_err++; $display("FAIL abort_quiet_r%0d: got %h want %h", r, outs(), ev(0, 0, 0, 0, 0, 8'd0));
      end
      last_cnt = 8'd0;
    end
    build_xfr(0, 1, 0);
    play("abort_fresh");
  endtask

  task automatic test_reack_guard();
    build_xfr(1, 20, 0);
    build_xfr(0, 1, 30);
    play("reack");
  endtask

  task automatic test_reset_mid_xfr();
    req = 1'b1; hold = 1'b0;
    for (int k = 0; k <= 6; k++) step();
    n_cmp++;
    if (xfr_cnt !== 8'd2) begin
      n_err++; $display("FAIL rstmid_pre: got cnt %0d want 2", xfr_cnt);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (outs() !== 13'd0) begin
      n_err++; $display("FAIL rstmid_after: got %h want %h", outs(), 13'd0);
    end
    rst = 1'b0; req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (outs() !== 13'd0) begin
        n_err++; $display("FAIL rstmid_quiet_%0d: got %h want %h", k, outs(), 13'd0);
      end
    end
    last_cnt = 8'd0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      build_xfr($urandom_range(3), $urandom_range(3), $urandom_range(60));
      play($sformatf("rand%0d", t));
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; hold = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wait_drop();
    test_xfr_abort();
    test_reack_guard();
    test_reset_mid_xfr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
